mcpu_writeback_unit: RTL and testbench

//  Write-side master for the MCPU register file: collects ALU results and memory load data,

---
 rtl/mcpu_pkg.sv | 31 +++
 rtl/mcpu_writeback_unit_if.sv | 40 ++++
 rtl/mcpu_wb_fifo.sv | 60 ++++++
 rtl/mcpu_writeback_unit.sv | 142 ++++++++++++++
 tb/tb_mcpu_writeback_unit.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/mcpu_pkg.sv
// Shared types and constants for the MCPU writeback path.
// Register-file widths, write command encoding and FIFO entry layout.
package mcpu_pkg;

  localparam int WORD_SIZE        = 8;
  localparam int OPERAND_SIZE     = 4;
  localparam int REGISTERS_NUMBER = 16;

  localparam logic [1:0] WB_CMD_LOAD = 2'b00;

  typedef enum logic [1:0] {
    WB_IDLE,
    WB_ACTIVE,
    WB_STALL
  } wb_state_t;

  typedef struct packed {
    logic [OPERAND_SIZE-1:0] dest;
    logic [WORD_SIZE-1:0]    data;
  } wb_entry_t;

  // Indices beyond the register count map to no bit at all.
  function automatic logic [REGISTERS_NUMBER-1:0] dest_onehot(
    input logic [OPERAND_SIZE-1:0] d
  );
    dest_onehot = '0;
    for (int r = 0; r < REGISTERS_NUMBER; r++)
      if (int'(d) == r) dest_onehot[r] = 1'b1;
  endfunction

endpackage

// File: rtl/mcpu_writeback_unit_if.sv
// Writeback unit bus: ALU/load offers, control, regfile write side.
// master = writeback unit, slave = producers / register file.
interface mcpu_writeback_unit_if;
  import mcpu_pkg::*;

  logic                        alu_valid;
  logic [OPERAND_SIZE-1:0]     alu_dest;
  logic [WORD_SIZE-1:0]        alu_result;
  logic                        alu_ready;
  logic                        mem_valid;
  logic [OPERAND_SIZE-1:0]     mem_dest;
  logic [WORD_SIZE-1:0]        mem_data;
  logic                        mem_ready;
  logic                        wb_hold;
  logic                        flush;
  logic [OPERAND_SIZE-1:0]     wb_op;
  logic [WORD_SIZE-1:0]        wb_data;
  logic [1:0]                  wb_cmd;
  logic                        wb_en;
  logic [REGISTERS_NUMBER-1:0] reg_busy;

  modport master (
    input  alu_valid, alu_dest, alu_result,
    input  mem_valid, mem_dest, mem_data,
    input  wb_hold, flush,
    output alu_ready, mem_ready,
    output wb_op, wb_data, wb_cmd, wb_en,
    output reg_busy
  );

  modport slave (
    output alu_valid, alu_dest, alu_result,
    output mem_valid, mem_dest, mem_data,
    output wb_hold, flush,
    input  alu_ready, mem_ready,
    input  wb_op, wb_data, wb_cmd, wb_en,
    input  reg_busy
  );

endinterface

// File: rtl/mcpu_wb_fifo.sv
// In-order pending-write FIFO, up to two pushes and one pop per edge.
// Exposes per-slot valid/dest taps for the register busy map.
module mcpu_wb_fifo
  import mcpu_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              clear,
  input  logic                              push0,
  input  wb_entry_t                         din0,
  input  logic                              push1,
  input  wb_entry_t                         din1,
  input  logic                              pop,
  output wb_entry_t                         head,
  output logic [CW-1:0]                     count,
  output logic [DEPTH-1:0]                  ent_vld,
  output logic [DEPTH-1:0][OPERAND_SIZE-1:0] ent_dest
);

  wb_entry_t     mem_q [DEPTH];
  logic [PW-1:0] wr_q, rd_q, wr_p1;
  logic [CW-1:0] count_q;

  assign wr_p1 = wr_q + PW'(1);
  assign head  = mem_q[rd_q];
  assign count = count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++)
        mem_q[i] <= '0;
    end else if (clear) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      if (push0) mem_q[wr_q]  <= din0;
      if (push1) mem_q[wr_p1] <= din1;
      wr_q    <= wr_q + PW'(push0) + PW'(push1);
      rd_q    <= rd_q + PW'(pop);
      count_q <= count_q + CW'(push0)
               + CW'(push1) - CW'(pop);
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_tap
    logic [PW-1:0] off;
    assign off         = PW'(i) - rd_q;
    assign ent_vld[i]  = {1'b0, off} < count_q;
    assign ent_dest[i] = mem_q[i].dest;
  end

endmodule

// File: rtl/mcpu_writeback_unit.sv
// MCPU writeback master: queues ALU/load results, one regfile write per cycle.
// Define WB_BYPASS_EN to let an entry skip the empty FIFO (1-cycle latency).
module mcpu_writeback_unit
  import mcpu_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input logic                  clk,
  input logic                  rst_n,
  mcpu_writeback_unit_if.master wb
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  wb_state_t state_q, state_d;
  wb_entry_t mem_ent, alu_ent, first_ent;
  wb_entry_t din0, head, out_q, load_ent;
  logic [CW-1:0] count, free;
  logic [FIFO_DEPTH-1:0] ent_vld;
  logic [FIFO_DEPTH-1:0][OPERAND_SIZE-1:0] ent_dest;
  logic mem_rdy, alu_rdy, acc_m, acc_a, any_acc;
  logic second_v, fifo_empty, can_issue;
  logic issue, byp, push0, push1, load, wb_en_q;
  logic [REGISTERS_NUMBER-1:0] busy;

  assign free       = CW'(FIFO_DEPTH) - count;
  assign fifo_empty = (count == '0);

  // Load data keeps priority on the last free slot.
  assign mem_rdy = !wb.flush && (free != '0);
  assign alu_rdy = !wb.flush
                && (free > CW'(1)
                 || (free != '0 && !wb.mem_valid));

  assign acc_m    = wb.mem_valid && mem_rdy;
  assign acc_a    = wb.alu_valid && alu_rdy;
  assign any_acc  = acc_m || acc_a;
  assign second_v = acc_m && acc_a;

  assign mem_ent   = '{dest: wb.mem_dest, data: wb.mem_data};
  assign alu_ent   = '{dest: wb.alu_dest, data: wb.alu_result};
  assign first_ent = acc_m ? mem_ent : alu_ent;

`ifdef WB_BYPASS_EN
  assign byp = any_acc && fifo_empty
            && !wb.wb_hold && !wb.flush;
`else
  assign byp = 1'b0;
`endif

  assign push0    = byp ? second_v : any_acc;
  assign din0     = byp ? alu_ent : first_ent;
  assign push1    = !byp && second_v;
  assign load     = issue || byp;
  assign load_ent = byp ? first_ent : head;

  mcpu_wb_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (wb.flush),
    .push0    (push0),
    .din0     (din0),
    .push1    (push1),
    .din1     (alu_ent),
    .pop      (issue),
    .head     (head),
    .count    (count),
    .ent_vld  (ent_vld),
    .ent_dest (ent_dest)
  );

  assign can_issue = !wb.flush && !wb.wb_hold
                  && !fifo_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= WB_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    unique case (state_q)
      WB_IDLE: begin
        if (wb.wb_hold && !wb.flush)
          state_d = WB_STALL;
        else if (any_acc)
          state_d = WB_ACTIVE;
      end
      WB_ACTIVE: begin
        issue = can_issue;
        if (wb.wb_hold && !wb.flush)
          state_d = WB_STALL;
        else if (!any_acc
              && (wb.flush || count <= CW'(1)))
          state_d = WB_IDLE;
      end
      WB_STALL: begin
        issue = can_issue;
        if (wb.wb_hold && !wb.flush)
          state_d = WB_STALL;
        else if (!wb.flush
              && (any_acc || count > CW'(1)))
          state_d = WB_ACTIVE;
        else
          state_d = WB_IDLE;
      end
      default: state_d = WB_IDLE;
    endcase
  end

  // Output stage: an entry loaded here is committed and always strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q   <= '0;
      wb_en_q <= 1'b0;
    end else begin
      wb_en_q <= load;
      if (load) out_q <= load_ent;
    end
  end

  always_comb begin
    busy = '0;
    for (int i = 0; i < FIFO_DEPTH; i++)
      if (ent_vld[i])
        busy = busy | dest_onehot(ent_dest[i]);
    if (wb_en_q)
      busy = busy | dest_onehot(out_q.dest);
  end

  assign wb.alu_ready = alu_rdy;
  assign wb.mem_ready = mem_rdy;
  assign wb.wb_op     = out_q.dest;
  assign wb.wb_data   = out_q.data;
  assign wb.wb_cmd    = WB_CMD_LOAD;
  assign wb.wb_en     = wb_en_q;
  assign wb.reg_busy  = busy;

endmodule

// File: tb/tb_mcpu_writeback_unit.sv
// Scoreboard bench for mcpu_writeback_unit: directed offers, queued expects.
// A negedge monitor checks every write strobe against the queue.
module tb_mcpu_writeback_unit;
  import mcpu_pkg::*;

`ifdef WB_BYPASS_EN
  localparam int LAT = 0;
`else
  localparam int LAT = 1;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;
  int   n_strobe = 0;
  int   s0;
  int   lat;
  bit   ma, aa;
  wb_entry_t exp_q[$];

  mcpu_writeback_unit_if wbi();

  mcpu_writeback_unit #(
    .FIFO_DEPTH (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .wb    (wbi)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && wbi.wb_en) begin
      wb_entry_t e;
      n_strobe++;
      if (exp_q.size() == 0) begin
        chk("unexpected_strobe",
            32'(wbi.wb_op), 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        chk("wb_op", 32'(wbi.wb_op), 32'(e.dest));
        chk("wb_data", 32'(wbi.wb_data), 32'(e.data));
        chk("wb_cmd", 32'(wbi.wb_cmd), 32'(2'b00));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic mv,
                       input logic [3:0] md,
                       input logic [7:0] mdat,
                       input logic av,
                       input logic [3:0] ad,
                       input logic [7:0] adat,
                       output bit m_acc,
                       output bit a_acc);
    wbi.mem_valid  = mv;
    wbi.mem_dest   = md;
    wbi.mem_data   = mdat;
    wbi.alu_valid  = av;
    wbi.alu_dest   = ad;
    wbi.alu_result = adat;
    @(negedge clk);
    m_acc = mv && wbi.mem_ready;
    a_acc = av && wbi.alu_ready;
    if (m_acc) exp_q.push_back('{dest: md, data: mdat});
    if (a_acc) exp_q.push_back('{dest: ad, data: adat});
    tick();
    wbi.mem_valid = 1'b0;
    wbi.alu_valid = 1'b0;
  endtask

  initial begin
    wbi.alu_valid  = 1'b0;
    wbi.alu_dest   = '0;
    wbi.alu_result = '0;
    wbi.mem_valid  = 1'b0;
    wbi.mem_dest   = '0;
    wbi.mem_data   = '0;
    wbi.wb_hold    = 1'b0;
    wbi.flush      = 1'b0;
    repeat (3) tick();
    chk("rst_wb_en", 32'(wbi.wb_en), 0);
    chk("rst_wb_op", 32'(wbi.wb_op), 0);
    chk("rst_wb_data", 32'(wbi.wb_data), 0);
    chk("rst_wb_cmd", 32'(wbi.wb_cmd), 0);
    chk("rst_busy", 32'(wbi.reg_busy), 0);
    rst_n = 1'b1;
    tick();

    // 1: reset in the middle of a burst
    offer(0, 0, 0, 1, 4'd10, 8'hA1, ma, aa);
    offer(0, 0, 0, 1, 4'd11, 8'hA2, ma, aa);
    offer(0, 0, 0, 1, 4'd12, 8'hA3, ma, aa);
    #1 rst_n = 1'b0;
    #1;
    chk("t1_wb_en", 32'(wbi.wb_en), 0);
    chk("t1_busy", 32'(wbi.reg_busy), 0);
    exp_q.delete();
    s0 = n_strobe;
    tick();
    rst_n = 1'b1;
    repeat (5) tick();
    chk("t1_no_strobe", 32'(n_strobe - s0), 0);

    // 2: single ALU write, latency and busy bit
    offer(0, 0, 0, 1, 4'd5, 8'h0F, ma, aa);
    chk("t2_acc", 32'(aa), 1);
    chk("t2_busy_set", 32'(wbi.reg_busy[5]), 1);
    lat = 0;
    while (!wbi.wb_en && lat < 5) begin
      tick();
      lat++;
    end
    chk("t2_latency", 32'(lat), 32'(LAT));
    chk("t2_wb_op", 32'(wbi.wb_op), 5);
    chk("t2_wb_data", 32'(wbi.wb_data), 32'h0F);
    chk("t2_busy_strobe", 32'(wbi.reg_busy[5]), 1);
    tick();
    chk("t2_busy_clr", 32'(wbi.reg_busy[5]), 0);
    chk("t2_wb_en_off", 32'(wbi.wb_en), 0);
    repeat (2) tick();

    // 3: simultaneous load and ALU result to the same register
    offer(1, 4'd3, 8'hAA, 1, 4'd3, 8'h55, ma, aa);
    chk("t3_mem_acc", 32'(ma), 1);
    chk("t3_alu_acc", 32'(aa), 1);
    for (int k = 0; k < LAT + 2; k++) begin
      chk("t3_busy_held", 32'(wbi.reg_busy[3]), 1);
      tick();
    end
    chk("t3_busy_clr", 32'(wbi.reg_busy[3]), 0);
    repeat (2) tick();

    // 4: fill under hold, then drain back-to-back
    wbi.wb_hold = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      offer(0, 0, 0, 1, 4'(k), 8'(k * 17), ma, aa);
      chk("t4_acc", 32'(aa), 1);
    end
    chk("t4_busy_map", 32'(wbi.reg_busy), 32'h001E);
    offer(1, 4'd13, 8'hEE, 1, 4'd14, 8'hDD, ma, aa);
    chk("t4_mem_full", 32'(ma), 0);
    chk("t4_alu_full", 32'(aa), 0);
    chk("t4_no_wb_en", 32'(wbi.wb_en), 0);
    wbi.wb_hold = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("t4_drain_en", 32'(wbi.wb_en), 1);
    end
    tick();
    chk("t4_drain_done", 32'(wbi.wb_en), 0);
    chk("t4_busy_end", 32'(wbi.reg_busy), 0);

    // 5: flush with three pending and one in the output stage
    wbi.wb_hold = 1'b1;
    for (int k = 6; k <= 9; k++)
      offer(0, 0, 0, 1, 4'(k), 8'(k + 8'h50), ma, aa);
    wbi.wb_hold = 1'b0;
    tick();
    chk("t5_out_loaded", 32'(wbi.wb_en), 1);
    s0 = n_strobe;
    wbi.flush = 1'b1;
    offer(1, 4'd12, 8'hEE, 1, 4'd13, 8'hDD, ma, aa);
    wbi.flush = 1'b0;
    exp_q.delete();
    chk("t5_mem_blocked", 32'(ma), 0);
    chk("t5_alu_blocked", 32'(aa), 0);
    chk("t5_busy_clr", 32'(wbi.reg_busy), 0);
    repeat (5) tick();
    chk("t5_one_strobe", 32'(n_strobe - s0), 1);

    // 6: one write to every register
    s0 = n_strobe;
    for (int i = 0; i < 16; i++) begin
      offer(0, 0, 0, 1, 4'(i), 8'h0F, ma, aa);
      chk("t6_acc", 32'(aa), 1);
    end
    for (int k = 0; k < 20 && exp_q.size() != 0; k++)
      tick();
    chk("t6_drained", 32'(exp_q.size()), 0);
    tick();
    chk("t6_strobes", 32'(n_strobe - s0), 16);
    chk("t6_busy_end", 32'(wbi.reg_busy), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_cmp, n_err);
    $finish;
  end

endmodule
